// File: rtl/multiword_add_pkg.sv
// ---------------------------------------------------------------------------
// multiword_add_pkg
// Shared definitions for the multiword add sequencer:
//   state_t        - FSM state encoding (IDLE / ADD / DONE)
//   DEF_WORD_W     - default width of the shared word adder
//   DEF_NUM_WORDS  - default operand length in words
// ---------------------------------------------------------------------------
package multiword_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WORD_W    = 4;
    localparam int DEF_NUM_WORDS = 4;

endpackage

// File: rtl/word_ripple_adder.sv
// ---------------------------------------------------------------------------
// word_ripple_adder
// Combinational WORD_W-bit adder with carry in/out. One instance is
// time-shared by the sequencer across all operand words.
//   a, b  in  WORD_W  addends
//   cin   in  1       carry in
//   sum   out WORD_W  a + b + cin (mod 2^WORD_W)
//   cout  out 1       carry out
// ---------------------------------------------------------------------------
module word_ripple_adder #(
    parameter int WORD_W = 4
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    // One extra bit on the left catches the carry out.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_sequencer.sv
// ---------------------------------------------------------------------------
// multiword_add_sequencer
// Adds two OP_W = WORD_W*NUM_WORDS bit operands one word per cycle, LSW
// first, through a single shared word_ripple_adder.
//
// Optional feature: define MULTIWORD_ADD_SEQUENCER_SUB_EN to add the `sub`
// input. With sub=1 the B operand is inverted and the initial carry forced
// to 1, so the result is A-B and carry=1 means "no borrow".
//
// Ports:
//   clk       in  1     clock, rising edge
//   rst       in  1     synchronous active-high reset
//   sub       in  1     subtract select (only with the macro)
//   start     in  1     request pulse, honoured only in IDLE
//   a_in      in  OP_W  operand A, captured on acceptance
//   b_in      in  OP_W  operand B, captured on acceptance
//   carry_in  in  1     initial carry, captured on acceptance
//   busy      out 1     high from the cycle after acceptance through DONE
//   done      out 1     one-cycle pulse while sum/carry are valid
//   sum       out OP_W  registered result
//   carry     out 1     registered final carry-out
// ---------------------------------------------------------------------------
module multiword_add_sequencer
    import multiword_add_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    localparam int OP_W     = WORD_W * NUM_WORDS
) (
    input  logic            clk,
    input  logic            rst,
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
    input  logic            sub,
`endif
    input  logic            start,
    input  logic [OP_W-1:0] a_in,
    input  logic [OP_W-1:0] b_in,
    input  logic            carry_in,
    output logic            busy,
    output logic            done,
    output logic [OP_W-1:0] sum,
    output logic            carry
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              cry_r;
    logic [OP_W-1:0]   a_r;
    logic [OP_W-1:0]   b_r;

    // Operand B and initial carry as loaded on acceptance; subtraction
    // folds into the same adder as A + ~B + 1.
    logic [OP_W-1:0]   b_load;
    logic              c_load;

    always_comb begin
        b_load = b_in;
        c_load = carry_in;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        if (sub) begin
            b_load = ~b_in;
            c_load = 1'b1;
        end
`endif
    end

    logic [WORD_W-1:0] w_sum;
    logic              w_cout;

    word_ripple_adder #(.WORD_W(WORD_W)) u_adder (
        .a    (a_r[idx*WORD_W +: WORD_W]),
        .b    (b_r[idx*WORD_W +: WORD_W]),
        .cin  (cry_r),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            cry_r <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a_in;
                        b_r   <= b_load;
                        cry_r <= c_load;
                        idx   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum[idx*WORD_W +: WORD_W] <= w_sum;
                    cry_r <= w_cout;
                    idx   <= idx + 1'b1;
                    // done is registered, so raise it on the edge that
                    // writes the last word; it is then high for the DONE cycle.
                    if (idx == LAST_IDX) begin
                        carry <= w_cout;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

    localparam int WORD_W    = 4;
    localparam int NUM_WORDS = 4;
    localparam int OP_W      = WORD_W * NUM_WORDS;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [OP_W-1:0] a_in;
    logic [OP_W-1:0] b_in;
    logic            carry_in;
    logic            busy;
    logic            done;
    logic [OP_W-1:0] sum;
    logic            carry;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
    logic            sub;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multiword_add_sequencer #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        .sub      (sub),
`endif
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry)
    );

    // Reference: full-width unsigned arithmetic, {carry,sum} = A + B' + c'
    function automatic logic [OP_W:0] ref_result(input logic [OP_W-1:0] a,
                                                 input logic [OP_W-1:0] b,
                                                 input logic ci, input logic sb);
        logic [OP_W:0] r;
        if (sb) r = {1'b0, a} + {1'b0, ~b} + (OP_W+1)'(1);
        else    r = {1'b0, a} + {1'b0, b} + {{OP_W{1'b0}}, ci};
        return r;
    endfunction

    // One transaction. Inputs are scrambled every cycle after acceptance;
    // optionally a competing start is raised while busy and in the DONE cycle.
    task automatic run_op(input string nm, input logic [OP_W-1:0] a,
                          input logic [OP_W-1:0] b, input logic ci,
                          input logic sb, input bit compete);
        logic [OP_W:0] exp;
        int busy_cnt, done_cnt, lat;
        exp = ref_result(a, b, ci, sb);
        @(negedge clk);
        a_in = a; b_in = b; carry_in = ci; start = 1'b1;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        sub = sb;
`endif
        @(negedge clk);   // accepted at the edge just passed
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; lat = -1;
        for (int c = 0; c < NUM_WORDS + 4; c++) begin
            if (compete && (c == 1 || c == NUM_WORDS)) start = 1'b1;
            else start = 1'b0;
            a_in = OP_W'($urandom); b_in = OP_W'($urandom); carry_in = 1'($urandom);
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
            sub = 1'($urandom);
`endif
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = c;
                    vectors++;
                    if ({carry, sum} !== exp) begin
                        miscompares++;
                        $display("FAIL %s result: got carry=%b sum=%h, want carry=%b sum=%h",
                                 nm, carry, sum, exp[OP_W], exp[OP_W-1:0]);
                    end
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        // done sampled at negedge #c is high during the cycle that ends at
        // edge c+1 after acceptance, so c == NUM_WORDS means edge NUM_WORDS+1.
        vectors++;
        if (lat !== NUM_WORDS) begin
            miscompares++;
            $display("FAIL %s latency: got %0d, want %0d", nm, lat, NUM_WORDS);
        end
        vectors++;
        if (busy_cnt !== NUM_WORDS + 1) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d, want %0d", nm, busy_cnt, NUM_WORDS + 1);
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d, want 1", nm, done_cnt);
        end
        vectors++;
        if ({busy, carry, sum} !== {1'b0, exp}) begin
            miscompares++;
            $display("FAIL %s idle_hold: got busy=%b carry=%b sum=%h, want busy=0 carry=%b sum=%h",
                     nm, busy, carry, sum, exp[OP_W], exp[OP_W-1:0]);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        a_in = 16'hABCD; b_in = 16'h1234; carry_in = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, carry, sum} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b carry=%b sum=%h, want all 0",
                     busy, done, carry, sum);
        end
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        run_op("add_small",  16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("add_cross",  16'h000F, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("add_maxcin", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("add_zero",   16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_op("ignore_start", 16'h0102, 16'h0304, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_abort();
        int done_seen;
        @(negedge clk);
        a_in = 16'h7777; b_in = 16'h8888; carry_in = 1'b1; start = 1'b1;
        @(negedge clk);   // ADD cycle 1
        start = 1'b0;
        @(negedge clk);   // ADD cycle 2
        @(negedge clk);   // ADD cycle 3
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, done, carry, sum} !== '0) begin
            miscompares++;
            $display("FAIL abort_state: got busy=%b done=%b carry=%b sum=%h, want all 0",
                     busy, done, carry, sum);
        end
        done_seen = 0;
        repeat (NUM_WORDS + 2) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        vectors++;
        if (done_seen !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d pulses, want 0", done_seen);
        end
        run_op("after_abort", 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_op("random", OP_W'($urandom), OP_W'($urandom), 1'($urandom), 1'b0, (i % 4) == 3);
    endtask

`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
    task automatic test_sub();
        run_op("sub_borrow",   16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            run_op("sub_random", OP_W'($urandom), OP_W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; carry_in = 1'b0;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        sub = 1'b0;
`endif
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_abort();
        test_random();
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 Parameter WORD_W, default 4: width of the shared word adder, in bits.
REQ-002 Parameter NUM_WORDS, default 4: operand length in words; total width OP_W = WORD_W*NUM_WORDS.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 a_in  input  OP_W  operand A; captured when start is accepted.
REQ-007 b_in  input  OP_W  operand B; captured when start is accepted.
REQ-008 carry_in  input  1  initial carry; captured when start is accepted.
REQ-009 busy  output  1  high from the cycle after acceptance through the DONE cycle.
REQ-010 done  output  1  one-cycle pulse when sum and carry become valid.
REQ-011 sum  output  OP_W  result, registered.
REQ-012 carry  output  1  final carry-out, registered.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-014 IDLE with start=1 SHALL capture a_in, b_in and carry_in, clear the word index to 0, and go to ADD.
REQ-015 In each ADD cycle, one WORD_W-bit add SHALL combine word[idx] of A, word[idx] of B and the carry register, with words taken LSW first.
REQ-016 The word sum SHALL be written to sum[idx*WORD_W +: WORD_W] and the carry-out to the carry register.
REQ-017 ADD SHALL last exactly NUM_WORDS cycles and then go to DONE.
REQ-018 DONE SHALL assert done for one cycle, present carry = the final carry register, and return to IDLE.
REQ-019 Latency: done SHALL be high exactly NUM_WORDS+1 cycles after the edge that accepted start.
REQ-020 start while busy SHALL be ignored, with no queuing and no effect on operands.
REQ-021 start asserted in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE.
REQ-022 sum and carry SHALL hold their last result in IDLE until the next acceptance.
REQ-023 On acceptance, sum SHALL clear to 0; partial sums are visible during ADD but are valid only when done=1.
REQ-024 Arithmetic is unsigned modulo 2^OP_W; overflow is reported only via carry.
REQ-025 a_in, b_in and carry_in changes after acceptance SHALL NOT affect the result.

Reset
REQ-026 With rst=1 at a clock edge, the FSM SHALL go to IDLE, and busy, done, sum, carry, the index and the carry register SHALL all become 0.
REQ-027 Reset SHALL override start in the same cycle.
REQ-028 Reset mid-operation SHALL abort the add with no done pulse.

Configuration
REQ-029 Macro MULTIWORD_ADD_SEQUENCER_SUB_EN SHALL add input port sub (1 bit), captured with the operands.
REQ-030 With the macro and sub=1, B words SHALL be bitwise inverted and the initial carry forced to 1, giving A-B; carry=1 means no borrow.
REQ-031 With the macro and sub=0, behaviour SHALL be identical to the macro-absent build.
REQ-032 Without the macro, no sub port SHALL exist and only addition is performed.

Structure
REQ-033 A shared package multiword_add_pkg SHALL hold the state enum typedef (IDLE/ADD/DONE) and the default WORD_W and NUM_WORDS constants.
REQ-034 The combinational WORD_W-bit ripple adder SHALL be a single sub-module, word_ripple_adder (ports a, b, cin, sum, cout), instantiated once and time-shared across words.

Verification (WORD_W=4, NUM_WORDS=4)
REQ-035 a=0x0002, b=0x0003, carry_in=0, start pulse -> done 5 cycles later; sum=0x0005, carry=0.
REQ-036 a=0xFFFF, b=0x0001, carry_in=0 -> sum=0x0000, carry=1; busy high for exactly 5 cycles.
REQ-037 a=0x000F, b=0x0000, carry_in=1 -> sum=0x0010, carry=0 (carry crosses a word boundary).
REQ-038 Second start 2 cycles after the first, with different operands -> ignored; result matches the first operands; exactly one done pulse.
REQ-039 rst at the 3rd ADD cycle -> busy=0, sum=0, carry=0 next cycle; no done; a following start of 0x1234+0x1111 -> 0x2345.
REQ-040 With MULTIWORD_ADD_SEQUENCER_SUB_EN, a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, carry=1.
